// File: rtl/jump_ctrl.sv
// Jump controller: moves a player sprite vertically through a
// rise / hover / fall cycle, one pixel per motion tick, and keeps the
// player glued to (or falling onto) the floor surface while idle.
module jump_ctrl #(
  parameter int TICK_DIV    = 80_000,
  parameter int JUMP_HEIGHT = 40,
  parameter int HOVER_TICKS = 8,
  parameter int GROUND_Y    = 700
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_req,
  input  logic [11:0] floor_y,
  output logic [11:0] ypos,
  output logic        airborne,
  output logic        jump_start
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = $clog2(JUMP_HEIGHT + 1);
  localparam int HW = (HOVER_TICKS > 1) ? $clog2(HOVER_TICKS) : 1;

  localparam logic [TW-1:0] TICK_MAX   = TW'(TICK_DIV - 1);
  localparam logic [RW-1:0] RISE_LAST  = RW'(JUMP_HEIGHT - 1);
  localparam logic [HW-1:0] HOVER_LAST = HW'(HOVER_TICKS - 1);
  localparam logic [11:0]   GROUND_Y_V = 12'(GROUND_Y);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RISE  = 2'd1,
    HOVER = 2'd2,
    FALL  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] tick_cnt, tick_cnt_n;
  logic [RW-1:0] rise_cnt, rise_cnt_n;
  logic [HW-1:0] hover_cnt, hover_cnt_n;
  logic [11:0]   ypos_n;
  logic          jump_req_q;
  logic          airborne_n;
  logic          jump_start_n;
  logic          tick;
  logic          press;

  // One step upward, clamped at the top of the screen so ypos never wraps.
  function automatic logic [11:0] rise_step(input logic [11:0] y);
    return (y == 12'd0) ? 12'd0 : y - 12'd1;
  endfunction

  // True when the next downward step would reach or pass the floor.
  function automatic logic fall_lands(input logic [11:0] y, input logic [11:0] f);
    return !((y + 12'd1) < f);
  endfunction

  assign tick  = (tick_cnt == TICK_MAX);
  assign press = jump_req & ~jump_req_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state, next position and counter updates.
  always_comb begin
    state_n     = state;
    ypos_n      = ypos;
    rise_cnt_n  = rise_cnt;
    hover_cnt_n = hover_cnt;
    unique case (state)
      IDLE: begin
        // Walking off a ledge wins over a simultaneous key press.
        if (ypos < floor_y) begin
          state_n = FALL;
        end else if (ypos > floor_y) begin
          ypos_n = floor_y;
        end else if (press) begin
          state_n    = RISE;
          rise_cnt_n = '0;
        end
      end
      RISE: begin
        if (tick) begin
          ypos_n     = rise_step(ypos);
          rise_cnt_n = rise_cnt + RW'(1);
          if (rise_cnt == RISE_LAST || ypos <= 12'd1) state_n = HOVER;
        end
      end
      HOVER: begin
        if (tick) begin
          if (hover_cnt == HOVER_LAST) state_n = FALL;
          else                         hover_cnt_n = hover_cnt + HW'(1);
        end
      end
      FALL: begin
        // The floor is re-sampled every step, so a floor that moves
        // mid-fall is still landed on exactly.
        if (tick) begin
          if (fall_lands(ypos, floor_y)) begin
            ypos_n  = floor_y;
            state_n = IDLE;
          end else begin
            ypos_n = ypos + 12'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (state_n == HOVER && state != HOVER) hover_cnt_n = '0;

    // Restarting the divider on every transition makes the first step
    // land a full tick period after entering a state.
    if (state_n != state || tick) tick_cnt_n = '0;
    else                          tick_cnt_n = tick_cnt + TW'(1);

    airborne_n   = (state_n != IDLE);
    jump_start_n = (state == IDLE) && (state_n == RISE);
  end

  // Position, counters, key history and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ypos       <= GROUND_Y_V;
      tick_cnt   <= '0;
      rise_cnt   <= '0;
      hover_cnt  <= '0;
      jump_req_q <= 1'b0;
      airborne   <= 1'b0;
      jump_start <= 1'b0;
    end else begin
      ypos       <= ypos_n;
      tick_cnt   <= tick_cnt_n;
      rise_cnt   <= rise_cnt_n;
      hover_cnt  <= hover_cnt_n;
      jump_req_q <= jump_req;
      airborne   <= airborne_n;
      jump_start <= jump_start_n;
    end
  end

endmodule
